// File: rtl/el2_exu_mul_receiver.sv
// Multiplier-node NoC endpoint: reassembles MSB-first flits into {rs1, rs2, mul_p}
// behind a registered valid/ready stage. Optional err_cnt under EL2_MUL_RX_ERRCHK_EN.
module el2_exu_mul_receiver #(
    parameter int PACKET_BITS = 73,
    parameter int FLIT_BITS   = 32,
    parameter int MUL_BITS    = PACKET_BITS - 64
) (
    input  logic                 clk_noc,
    input  logic                 rst,
    input  logic                 noc_valid,
    input  logic                 noc_sop,
    input  logic [FLIT_BITS-1:0] noc_data,
    output logic                 noc_ready,
    input  logic                 noc_sr_flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          rs1_out,
    output logic [31:0]          rs2_out,
    output logic [MUL_BITS-1:0]  mul_p_out
`ifdef EL2_MUL_RX_ERRCHK_EN
   ,output logic [7:0]           err_cnt
`endif
);

    localparam int NFLITS = (PACKET_BITS + FLIT_BITS - 1) / FLIT_BITS;
    localparam int SR_W   = NFLITS * FLIT_BITS;
    localparam int CNT_W  = (NFLITS > 1) ? $clog2(NFLITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NFLITS - 1);

    typedef enum logic {IDLE, COLLECT} state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [SR_W-1:0]       sr_q;
    logic                  out_valid_q;
    logic [31:0]           rs1_q, rs2_q;
    logic [MUL_BITS-1:0]   mul_p_q;

    logic [SR_W-1:0]       flit_ext, sr_d;
    logic                  last_pending, accept, proto_err;

    assign flit_ext = SR_W'(noc_data);
    // With a single flit per packet the incoming flit alone is the whole packet.
    assign sr_d     = (NFLITS > 1) ? ((sr_q << FLIT_BITS) | flit_ext) : flit_ext;

    // Only the packet-completing flit is held off by a stalled output register.
    assign last_pending = (cnt_q == LAST);
    assign noc_ready    = !noc_sr_flush && !(last_pending && out_valid_q && !out_ready);
    assign accept       = noc_valid && noc_ready;
    assign proto_err    = accept && ((state_q == IDLE) != noc_sop);

    always_ff @(posedge clk_noc or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            out_valid_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            mul_p_q     <= '0;
        end else if (noc_sr_flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_ready) out_valid_q <= 1'b0;
            if (accept) begin
                if (noc_sop) begin
                    if (NFLITS == 1) begin
                        out_valid_q <= 1'b1;
                        rs1_q       <= sr_d[PACKET_BITS-1 -: 32];
                        rs2_q       <= sr_d[PACKET_BITS-33 -: 32];
                        mul_p_q     <= sr_d[MUL_BITS-1:0];
                    end else begin
                        // Fresh start, also the resync point after a misplaced sop.
                        sr_q    <= flit_ext;
                        cnt_q   <= CNT_W'(1);
                        state_q <= COLLECT;
                    end
                end else if (state_q == COLLECT) begin
                    if (cnt_q == LAST) begin
                        out_valid_q <= 1'b1;
                        rs1_q       <= sr_d[PACKET_BITS-1 -: 32];
                        rs2_q       <= sr_d[PACKET_BITS-33 -: 32];
                        mul_p_q     <= sr_d[MUL_BITS-1:0];
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                    end else begin
                        sr_q  <= sr_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign rs1_out   = rs1_q;
    assign rs2_out   = rs2_q;
    assign mul_p_out = mul_p_q;

    logic unused_pad;
    assign unused_pad = ^(sr_d >> PACKET_BITS);

`ifdef EL2_MUL_RX_ERRCHK_EN
    logic [7:0] err_cnt_q;

    // Saturating; flush leaves it alone so errors survive a pipeline abort.
    always_ff @(posedge clk_noc or posedge rst) begin
        if (rst)                                err_cnt_q <= '0;
        else if (proto_err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_err;
    assign unused_err = proto_err;
`endif

endmodule

// File: tb/tb_el2_exu_mul_receiver.sv
// Bench for el2_exu_mul_receiver: packet table, directed corner sequences and a
// randomized run against a flit-queue reference model.
module tb_el2_exu_mul_receiver;

    localparam int PB = 73;
    localparam int FB = 32;
    localparam int MB = PB - 64;

    logic          clk_noc = 1'b0;
    logic          rst;
    logic          noc_valid, noc_sop, noc_ready, noc_sr_flush;
    logic [FB-1:0] noc_data;
    logic          out_valid, out_ready;
    logic [31:0]   rs1_out, rs2_out;
    logic [MB-1:0] mul_p_out;
`ifdef EL2_MUL_RX_ERRCHK_EN
    logic [7:0]    err_cnt;
`endif

    el2_exu_mul_receiver #(.PACKET_BITS(PB), .FLIT_BITS(FB), .MUL_BITS(MB)) dut (
        .clk_noc(clk_noc), .rst(rst),
        .noc_valid(noc_valid), .noc_sop(noc_sop), .noc_data(noc_data),
        .noc_ready(noc_ready), .noc_sr_flush(noc_sr_flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .rs1_out(rs1_out), .rs2_out(rs2_out), .mul_p_out(mul_p_out)
`ifdef EL2_MUL_RX_ERRCHK_EN
       ,.err_cnt(err_cnt)
`endif
    );

    always #5 clk_noc = ~clk_noc;

    typedef struct {
        logic [31:0]   f0, f1, f2;
        logic [31:0]   rs1, rs2;
        logic [MB-1:0] mul;
    } vec_t;

    vec_t tbl[5];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
    task automatic cyc();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d);
        noc_valid = v; noc_sop = s; noc_data = d;
    endtask

    task automatic send_pkt(input vec_t t);
        drive(1, 1, t.f0); cyc();
        drive(1, 0, t.f1); cyc();
        drive(1, 0, t.f2); cyc();
        drive(0, 0, 32'h0);
    endtask

    task automatic chk_out(input string name, input vec_t t);
        #1;
        chk({name, " valid"}, out_valid, 1'b1);
        chk({name, " rs1"},   rs1_out, t.rs1);
        chk({name, " rs2"},   rs2_out, t.rs2);
        chk({name, " mul_p"}, mul_p_out, t.mul);
    endtask

    // Reference model state: flits of the packet being built, packets held at output.
    logic [31:0] part[$];
    logic [PB-1:0] held[$];
    int model_err;

    initial begin
        logic [PB-1:0] pk;
        logic          exp_rdy, v, s, fl, r;
        logic [31:0]   d;

        tbl[0] = '{32'h00000024, 32'h68ACF1FF, 32'hFFFFFDA5, 32'h12345678, 32'hFFFFFFFE, 9'h1A5};
        tbl[1] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 9'h000};
        tbl[2] = '{32'h000001FF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 9'h1FF};
        tbl[3] = '{32'h00000100, 32'h00000000, 32'h00000200, 32'h80000000, 32'h00000001, 9'h000};
        // Ones in the padding bits of flit 0 must be discarded.
        tbl[4] = '{32'hFFFFFFBD, 32'h5B7DDE02, 32'h468ACEAB, 32'hDEADBEEF, 32'h01234567, 9'h0AB};

        rst = 1'b1; noc_sr_flush = 1'b0; out_ready = 1'b0;
        drive(0, 0, 32'h0);
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset noc_ready", noc_ready, 1'b1);
        chk("reset rs1", rs1_out, 32'h0);
        chk("reset rs2", rs2_out, 32'h0);
        chk("reset mul_p", mul_p_out, 9'h0);
`ifdef EL2_MUL_RX_ERRCHK_EN
        chk("reset err_cnt", err_cnt, 8'd0);
`endif
        cyc();

        // Table: single packets with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_pkt(tbl[i]);
            chk_out($sformatf("tbl%0d", i), tbl[i]);
            cyc();
            #1 chk($sformatf("tbl%0d one-cycle valid", i), out_valid, 1'b0);
            cyc();
        end

        // Back-to-back with a stalled consumer; release coincides with completion.
        out_ready = 1'b0;
        send_pkt(tbl[0]);
        drive(1, 1, tbl[1].f0); #1 chk("b2b B f0 ready", noc_ready, 1'b1); cyc();
        drive(1, 0, tbl[1].f1); #1 chk("b2b B f1 ready", noc_ready, 1'b1); cyc();
        drive(1, 0, tbl[1].f2);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("b2b B f2 stalled", noc_ready, 1'b0);
            chk("b2b A held rs1", rs1_out, tbl[0].rs1);
            chk("b2b A held valid", out_valid, 1'b1);
            cyc();
        end
        out_ready = 1'b1;
        #1 chk("b2b release ready", noc_ready, 1'b1);
        cyc();
        drive(0, 0, 32'h0);
        chk_out("b2b B", tbl[1]);
        cyc();
        #1 chk("b2b drained", out_valid, 1'b0);
        cyc();

        // Flush mid-packet while a packet is held.
        out_ready = 1'b0;
        send_pkt(tbl[2]);
        drive(1, 1, tbl[3].f0); cyc();
        drive(1, 0, tbl[3].f1); cyc();
        noc_sr_flush = 1'b1; drive(1, 0, tbl[3].f2);
        #1 chk("flush ready", noc_ready, 1'b0);
        cyc();
        noc_sr_flush = 1'b0; drive(0, 0, 32'h0);
        #1 chk("flush drops output", out_valid, 1'b0);
        out_ready = 1'b1;
        send_pkt(tbl[4]);
        chk_out("post-flush", tbl[4]);
        cyc();

        // Protocol errors: orphan continuation flit, then sop interrupting a packet.
        drive(1, 0, 32'hCAFEF00D); cyc();
        drive(1, 1, 32'h0BADBEEF); cyc();
        send_pkt(tbl[0]);
        chk_out("resync", tbl[0]);
`ifdef EL2_MUL_RX_ERRCHK_EN
        chk("err_cnt", err_cnt, 8'd2);
`endif
        cyc();

        // Asynchronous reset mid-packet while a packet is held.
        out_ready = 1'b0;
        send_pkt(tbl[2]);
        drive(1, 1, tbl[3].f0); cyc();
        drive(0, 0, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("async rst valid", out_valid, 1'b0);
        chk("async rst rs1", rs1_out, 32'h0);
        chk("async rst rs2", rs2_out, 32'h0);
        chk("async rst mul_p", mul_p_out, 9'h0);
`ifdef EL2_MUL_RX_ERRCHK_EN
        chk("async rst err_cnt", err_cnt, 8'd0);
`endif
        cyc();
        rst = 1'b0; out_ready = 1'b1;
        send_pkt(tbl[3]);
        chk_out("post-reset", tbl[3]);
        cyc();
        cyc();

        // Randomized run against the flit-queue model.
        part.delete(); held.delete(); model_err = 0;
        for (int c = 0; c < 3000; c++) begin
            v  = ($urandom_range(3) != 0);
            s  = (part.size() == 0) ? ($urandom_range(9) != 0) : ($urandom_range(9) == 0);
            d  = $urandom;
            fl = ($urandom_range(39) == 0);
            r  = ($urandom_range(2) != 0);
            drive(v, s, d); noc_sr_flush = fl; out_ready = r;
            exp_rdy = !fl && !(part.size() == 2 && held.size() > 0 && !r);
            #1;
            chk("rnd noc_ready", noc_ready, exp_rdy);
            chk("rnd out_valid", out_valid, held.size() > 0);
            if (held.size() > 0)
                chk("rnd packet", {rs1_out, rs2_out, mul_p_out}, held[0]);
            if (fl) begin
                part.delete(); held.delete();
            end else begin
                if (held.size() > 0 && r) void'(held.pop_front());
                if (v && exp_rdy) begin
                    if (s) begin
                        if (part.size() > 0) model_err++;
                        part.delete();
                        part.push_back(d);
                    end else if (part.size() == 0) begin
                        model_err++;
                    end else begin
                        part.push_back(d);
                    end
                    if (part.size() == 3) begin
                        pk = PB'({part[0], part[1], part[2]});
                        held.push_back(pk);
                        part.delete();
                    end
                end
            end
            cyc();
        end
        drive(0, 0, 32'h0); noc_sr_flush = 1'b0;
`ifdef EL2_MUL_RX_ERRCHK_EN
        #1 chk("rnd err_cnt", err_cnt, (model_err > 255) ? 8'd255 : 8'(model_err));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/el2_exu_mul_receiver.md
# el2_exu_mul_receiver

Deserializing NoC endpoint at the multiplier wrapper node that reassembles serial multiply-request packets into the operand bus consumed by the multiplier. Accepts fixed-width flits from the NoC, rebuilds the `{rs1, rs2, mul_p}` packet, and presents it through a registered valid/ready output stage. Sits directly downstream of the multiply sender and the NoC router, and directly upstream of the multiplier datapath.

## Interface
- PACKET_BITS, 73, packet width: 32 rs1 + 32 rs2 + MUL_BITS (packet MSB = rs1[31]).
- FLIT_BITS, 32, NoC flit payload width.
- MUL_BITS, PACKET_BITS-64, mul_p field width; the wrapper casts it to el2_mul_pkt_t.
- clk_noc  in  1  Exu NoC clock, the only clock.
- rst  in  1  Asynchronous, active-high reset.
- noc_valid  in  1  Flit present, from node_port.down.
- noc_sop  in  1  Flit is first of a packet.
- noc_data  in  FLIT_BITS  Flit payload.
- noc_ready  out  1  Flit accepted when noc_valid && noc_ready.
- noc_sr_flush  in  1  Abort partial packet and drop held output.
- out_valid  out  1  Reassembled packet available.
- out_ready  in  1  Consumer takes packet when out_valid && out_ready.
- rs1_out  out  32  A operand.
- rs2_out  out  32  B operand.
- mul_p_out  out  MUL_BITS  Multiply control packet.
- err_cnt  out  8  Protocol error count; only present with EL2_MUL_RX_ERRCHK_EN.

## Operation
- NFLITS = ceil(PACKET_BITS/FLIT_BITS), which is 3 at the defaults. The packet is zero-padded at the MSB end to NFLITS*FLIT_BITS bits. The first flit carries the most significant bits.
- Assembly FSM states: IDLE and COLLECT. A flit counter (clog2(NFLITS) bits) and a shift register of NFLITS*FLIT_BITS bits are assembled alongside the FSM.
- IDLE: an accepted flit with noc_sop=1 loads the shift register, sets count=1 and moves to COLLECT. If NFLITS=1 it completes immediately.
- IDLE: an accepted flit with noc_sop=0 is dropped. This is a protocol error.
- COLLECT: an accepted flit without sop shifts in and increments count. When count reaches NFLITS the packet is complete: it is copied to the output register, out_valid sets, and the FSM returns to IDLE with count=0.
- COLLECT: an accepted flit with sop is a protocol error. The partial packet is discarded and the block restarts with this flit as flit 1 (count=1).
- Output register: out_valid is held until out_valid && out_ready. Data must stay stable while out_valid=1 && out_ready=0.
- Back-pressure: noc_ready = !noc_sr_flush && !(completing flit would arrive while out_valid && !out_ready). Non-final flits are always accepted, so assembly of the next packet overlaps with a stalled output.
- Simultaneous completion and consume (out_ready=1 in the same cycle): the output register reloads with the new packet and out_valid stays 1. No bubble.
- Flush has priority over everything:
  - The FSM goes to IDLE, count goes to 0 and out_valid goes to 0.
  - noc_ready=0 during flush, so no flit is accepted in a flush cycle.
  - The shift and output registers need not be cleared.
- Reset values: FSM=IDLE, count=0, out_valid=0, noc_ready=1 (combinational, with flush low), rs1_out/rs2_out/mul_p_out=0, err_cnt=0.

## Timing
- Latency: out_valid rises in the cycle after the final flit is accepted. The minimum packet-to-output time is NFLITS+1 cycles from the first flit.
- Reset is asynchronous on assertion. All state is cleared while rst=1.
- noc_ready is combinational from out_valid, out_ready, count and noc_sr_flush. It has no combinational dependency on noc_valid or noc_data.
- Outputs rs1_out, rs2_out, mul_p_out and out_valid are driven directly by flops.
- Throughput: one packet per NFLITS cycles when out_ready=1.

## Configuration
- EL2_MUL_RX_ERRCHK_EN defined: the err_cnt port and an 8-bit counter exist.
  - The counter increments once per protocol error (non-sop flit in IDLE, or sop flit in COLLECT).
  - It saturates at 255 and is cleared only by rst; flush does not clear it.
- EL2_MUL_RX_ERRCHK_EN undefined: the port and the counter are absent. Error recovery (drop or resync) is identical.

## Test plan
- Three flits (sop, -, -) for rs1=0x12345678, rs2=0xFFFFFFFE, mul_p=0x1A5, with out_ready=1 -> one-cycle out_valid 1 cycle after the third flit, with exactly those field values.
- Two back-to-back packets, out_ready=0 until 5 cycles after the first completes:
  - noc_ready=0 only while the second packet's third flit is pending.
  - The first packet is held stable.
  - The second packet appears on the cycle after out_ready=1, with no loss.
- Completion coincident with out_ready=1 on a held packet -> out_valid stays 1 and the data switches to the new packet the next cycle.
- noc_sr_flush asserted after flit 2 of 3 -> noc_ready=0 that cycle and out_valid=0. The next full packet is reassembled correctly.
- Protocol errors (non-sop flit in IDLE; sop at flit 2) -> the first flit is dropped and assembly resyncs on the new sop. With EL2_MUL_RX_ERRCHK_EN, err_cnt=2.
- rst pulse mid-packet (after flit 1) with out_valid=1 -> all outputs are 0 asynchronously. A following clean packet is received correctly.
